reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised register file with an integrated write-back scoreboard for the pipelined datapath. Two combinational read ports and one synchronous write port. Each register has a pending-write counter, so decode can detect RAW hazards on source operands and stall. Sits in the decode stage: decode drives the read and issue ports, write-back drives the write port.

## Interface
Parameters:
- DW, 32, data width in bits
- AW, 5, address width; depth = 2**AW registers
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never marked pending
- PW, 2, pending-counter width; max outstanding writes per register = 2**PW-1

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- RA1  in  AW  read address, port 1 (rs)
- RA2  in  AW  read address, port 2 (rt)
- RD1  out  DW  read data, port 1
- RD2  out  DW  read data, port 2
- BUSY1  out  1  RA1 has at least one pending write
- BUSY2  out  1  RA2 has at least one pending write
- WE  in  1  write-back enable
- WA  in  AW  write-back address
- WD  in  DW  write-back data
- ISSUE  in  1  reserve destination IA (instruction issued)
- IA  in  AW  issue destination address
- ISSUE_FULL  out  1  IA counter saturated; an ISSUE this cycle is refused
- WB_ERR  out  1  sticky: write-back seen for a register with zero pending count

## Operation
- Storage: 2**AW x DW array, plus a PW-bit pending counter per register.
- Reads are combinational: RDn = mem[RAn]. BUSYn = (cnt[RAn] != 0).
- With ZERO_REG=1 and RAn==0: RDn=0 and BUSYn=0.
- Write: on the rising edge with WE=1, mem[WA] <= WD. Ignored when ZERO_REG=1 and WA==0.
- Issue: on the rising edge with ISSUE=1 and ISSUE_FULL=0, cnt[IA] increments.
  - ISSUE_FULL = ISSUE && cnt[IA]==2**PW-1 (combinational).
  - A refused issue leaves state unchanged. Upstream must hold the instruction and retry.
- Write-back retire: on the rising edge with WE=1 and cnt[WA]!=0, cnt[WA] decrements.
  - If WE=1 and cnt[WA]==0, the data is still written, the count stays 0, and WB_ERR sets.
- Simultaneous ISSUE and WE on the same address:
  - Net counter change is 0.
  - If that counter is 0, the issue increments and the write-back decrements, so it stays 0 and WB_ERR does not set.
  - If the counter is saturated, ISSUE_FULL does not assert, because the retire frees a slot.
- ZERO_REG=1: issue or write-back to address 0 never changes cnt[0] and never sets WB_ERR.
- Counter arithmetic is unsigned PW-bit. Wrap-around never occurs, because of the saturation guard and the zero guard.

## Timing
- Read latency is 0 cycles; new data is visible at RDn the cycle after the write edge.
- BUSYn and ISSUE_FULL update the cycle after the edge that changes a counter.
- Reset (RST_N=0, asynchronous, any time including mid-operation):
  - All mem entries and all counters clear to 0; WB_ERR clears to 0.
  - So RD1=RD2=0, BUSY1=BUSY2=0, ISSUE_FULL=0.
  - Writes and issues are ignored while RST_N=0.
  - Operation resumes on the first rising edge after release.
- WB_ERR, once set, holds until reset.

## Configuration
- RF_BYPASS_EN defined: write-through forwarding.
  - If WE=1 and WA==RAn (excluding the zero register when ZERO_REG=1), then RDn=WD in the same cycle.
  - BUSYn is 0 when that write retires the last pending count, i.e. cnt[RAn]==1 and no same-address ISSUE.
- RF_BYPASS_EN undefined:
  - RDn shows the old value until the edge.
  - BUSYn reflects the registered counter only.

## Test plan
- Reset clears state: write 0xDEADBEEF to r5, then pulse RST_N low mid-cycle -> RD1 (RA1=5) reads 0 immediately, BUSY1=0, WB_ERR=0.
- Zero register: WE=1, WA=0, WD=0xFFFFFFFF and ISSUE to IA=0 -> RD1 (RA1=0)=0, BUSY1=0, no WB_ERR.
- Scoreboard round trip: ISSUE r7 -> BUSY2=1 (RA2=7); WE r7 with WD=0x12345678 -> next cycle BUSY2=0, RD2=0x12345678.
- Saturation: three ISSUEs to r3 (PW=2) -> fourth gives ISSUE_FULL=1 and count stays 3; same-cycle ISSUE+WE on r3 -> ISSUE_FULL=0, count stays 3.
- Error flag: WE r9 with cnt=0 -> data written, WB_ERR=1 and sticky across later valid traffic until RST_N low.
- Bypass: WE=1, WA=RA1=4, WD=0xA5A5A5A5 -> with RF_BYPASS_EN, RD1=0xA5A5A5A5 in the same cycle; without it, RD1 shows the old value until the edge.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with a per-register pending-write scoreboard for decode-stage RAW hazard detection.
// Optional macro RF_BYPASS_EN: write-through forwarding from the write-back port to both read ports.
module reg_file_sb #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned PW       = 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [AW-1:0] RA1,
    input  logic [AW-1:0] RA2,
    output logic [DW-1:0] RD1,
    output logic [DW-1:0] RD2,
    output logic          BUSY1,
    output logic          BUSY2,
    input  logic          WE,
    input  logic [AW-1:0] WA,
    input  logic [DW-1:0] WD,
    input  logic          ISSUE,
    input  logic [AW-1:0] IA,
    output logic          ISSUE_FULL,
    output logic          WB_ERR
);

    localparam int unsigned DEPTH   = 2 ** AW;
    localparam logic [PW-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0] CNT_ONE = PW'(1);

    logic [DW-1:0] mem     [DEPTH];
    logic [PW-1:0] cnt     [DEPTH];
    logic [PW-1:0] cnt_nxt [DEPTH];
    logic          wb_err_q;

    logic          we_v;
    logic          iss_v;
    logic          full_c;
    logic          wb_bad_c;
    logic [DW-1:0] rd1_c;
    logic [DW-1:0] rd2_c;
    logic          busy1_c;
    logic          busy2_c;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Qualified write-back and issue; a same-address retire frees a slot for a saturated issue.
    assign we_v     = WE && RST_N && !is_zero(WA);
    assign full_c   = ISSUE && (cnt[IA] == CNT_MAX) && !(we_v && (WA == IA));
    assign iss_v    = ISSUE && RST_N && !full_c && !is_zero(IA);
    assign wb_bad_c = we_v && (cnt[WA] == '0) && !(iss_v && (IA == WA));

    // Per-register counter update; simultaneous issue and retire on one register cancel out.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_nxt[i] = cnt[i];
            if (iss_v && (IA == AW'(i)) &&
                !(we_v && (WA == AW'(i)))) begin
                cnt_nxt[i] = cnt[i] + CNT_ONE;
            end else if (we_v && (WA == AW'(i)) && (cnt[i] != '0) &&
                         !(iss_v && (IA == AW'(i)))) begin
                cnt_nxt[i] = cnt[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we_v) begin
            mem[WA] <= WD;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cnt[i] <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            if (wb_bad_c) begin
                wb_err_q <= 1'b1;
            end
        end
    end

    // Combinational read ports with hazard flags.
    always_comb begin
        rd1_c   = is_zero(RA1) ? '0 : mem[RA1];
        rd2_c   = is_zero(RA2) ? '0 : mem[RA2];
        busy1_c = !is_zero(RA1) && (cnt[RA1] != '0);
        busy2_c = !is_zero(RA2) && (cnt[RA2] != '0);
`ifdef RF_BYPASS_EN
        if (we_v && (WA == RA1)) begin
            rd1_c = WD;
            if ((cnt[RA1] == CNT_ONE) && !(iss_v && (IA == RA1))) begin
                busy1_c = 1'b0;
            end
        end
        if (we_v && (WA == RA2)) begin
            rd2_c = WD;
            if ((cnt[RA2] == CNT_ONE) && !(iss_v && (IA == RA2))) begin
                busy2_c = 1'b0;
            end
        end
`endif
    end

    assign RD1        = rd1_c;
    assign RD2        = rd2_c;
    assign BUSY1      = busy1_c;
    assign BUSY2      = busy2_c;
    assign ISSUE_FULL = full_c;
    assign WB_ERR     = wb_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: driver pushes expected outputs from a reference model, monitor compares.
module tb_reg_file_sb;

    logic        CLK;
    logic        RST_N;
    logic [4:0]  RA1, RA2, WA, IA;
    logic [31:0] RD1, RD2, WD;
    logic        BUSY1, BUSY2, WE, ISSUE, ISSUE_FULL, WB_ERR;

    reg_file_sb dut (
        .CLK(CLK), .RST_N(RST_N),
        .RA1(RA1), .RA2(RA2), .RD1(RD1), .RD2(RD2),
        .BUSY1(BUSY1), .BUSY2(BUSY2),
        .WE(WE), .WA(WA), .WD(WD),
        .ISSUE(ISSUE), .IA(IA),
        .ISSUE_FULL(ISSUE_FULL), .WB_ERR(WB_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        b1;
        logic        b2;
        logic        full;
        logic        err;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: plain arrays and integer pending counts.
    logic [31:0] mmem [32];
    int          mcnt [32];
    bit          merr;

    function automatic void m_clear();
        for (int i = 0; i < 32; i++) begin
            mmem[i] = 32'h0;
            mcnt[i] = 0;
        end
        merr = 1'b0;
    endfunction

    function automatic logic [31:0] m_rd(logic [4:0] ra, bit we, logic [4:0] wa, logic [31:0] wd);
        if (ra == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (we && wa == ra) return wd;
`endif
        return mmem[ra];
    endfunction

    function automatic logic m_busy(logic [4:0] ra, bit we, logic [4:0] wa, bit iss, logic [4:0] ia);
        if (ra == 5'd0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (we && wa == ra && mcnt[ra] == 1 && !(iss && ia == ra)) return 1'b0;
`endif
        return mcnt[ra] != 0;
    endfunction

    function automatic logic m_full(bit iss, logic [4:0] ia, bit we, logic [4:0] wa);
        return iss && ia != 5'd0 && mcnt[ia] == 3 && !(we && wa == ia);
    endfunction

    function automatic void m_edge(bit we, logic [4:0] wa, logic [31:0] wd, bit iss, logic [4:0] ia);
        if (iss && ia != 5'd0 && !m_full(iss, ia, we, wa)) mcnt[ia] = mcnt[ia] + 1;
        if (we && wa != 5'd0) begin
            mmem[wa] = wd;
            if (mcnt[wa] > 0) mcnt[wa] = mcnt[wa] - 1;
            else merr = 1'b1;
        end
    endfunction

    // One cycle of stimulus; expectation depends on RST_N as currently driven.
    task automatic step(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                        input bit iss, input logic [4:0] ia,
                        input logic [4:0] r1, input logic [4:0] r2, input string tag);
        exp_t e;
        WE = we; WA = wa; WD = wd; ISSUE = iss; IA = ia; RA1 = r1; RA2 = r2;
        e.tag = tag;
        if (!RST_N) begin
            m_clear();
            e.rd1 = 32'h0; e.rd2 = 32'h0; e.b1 = 1'b0; e.b2 = 1'b0; e.full = 1'b0; e.err = 1'b0;
        end else begin
            e.rd1  = m_rd(r1, we, wa, wd);
            e.rd2  = m_rd(r2, we, wa, wd);
            e.b1   = m_busy(r1, we, wa, iss, ia);
            e.b2   = m_busy(r2, we, wa, iss, ia);
            e.full = m_full(iss, ia, we, wa);
            e.err  = merr;
        end
        sbq.push_back(e);
        @(posedge CLK);
        if (RST_N) m_edge(we, wa, wd, iss, ia);
        #1;
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2, input string tag);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, r1, r2, tag);
    endtask

    task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got %h expected %h", tag, name, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, sampled mid-cycle on the falling edge.
    always @(negedge CLK) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("rd1",  e.tag, RD1, e.rd1);
            chk("rd2",  e.tag, RD2, e.rd2);
            chk("busy1", e.tag, 32'(BUSY1), 32'(e.b1));
            chk("busy2", e.tag, 32'(BUSY2), 32'(e.b2));
            chk("full", e.tag, 32'(ISSUE_FULL), 32'(e.full));
            chk("wberr", e.tag, 32'(WB_ERR), 32'(e.err));
        end
    end

    initial begin
        int drain;
        m_clear();
        RST_N = 1'b0; WE = 1'b0; WA = '0; WD = '0; ISSUE = 1'b0; IA = '0; RA1 = '0; RA2 = '0;
        @(posedge CLK); #1;
        step(1'b1, 5'd2, 32'h1111_2222, 1'b1, 5'd2, 5'd2, 5'd0, "rst_hold");
        RST_N = 1'b1;
        idle(5'd2, 5'd3, "post_rst");

        step(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd5, 5'd0, "wr_r5");
        idle(5'd5, 5'd0, "rd_r5");
        #2 RST_N = 1'b0;
        step(1'b1, 5'd5, 32'h0BAD_0BAD, 1'b1, 5'd5, 5'd5, 5'd5, "rst_mid");
        RST_N = 1'b1;
        idle(5'd5, 5'd5, "rst_clear");

        step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 5'd0, "zero_wr");
        idle(5'd0, 5'd0, "zero_rd");

        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd7, "iss_r7");
        step(1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 5'd0, 5'd7, "wb_r7");
        idle(5'd0, 5'd7, "rt_r7");

        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, "sat_fill");
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, "sat_full");
        step(1'b1, 5'd3, 32'h3333_3333, 1'b1, 5'd3, 5'd3, 5'd0, "sat_iss_wb");
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd3, 5'd0, "sat_still");

        step(1'b1, 5'd9, 32'h9999_0009, 1'b0, 5'd0, 5'd9, 5'd0, "err_wb");
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 5'd9, 5'd10, "err_sticky1");
        step(1'b1, 5'd10, 32'hAAAA_000A, 1'b0, 5'd0, 5'd9, 5'd10, "err_sticky2");
        idle(5'd9, 5'd10, "err_sticky3");

        idle(5'd4, 5'd0, "byp_pre");
        step(1'b1, 5'd4, 32'hA5A5_A5A5, 1'b0, 5'd0, 5'd4, 5'd0, "byp_same");
        idle(5'd4, 5'd0, "byp_post");
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 5'd0, 5'd4, "byp_iss");
        step(1'b1, 5'd4, 32'h5A5A_5A5A, 1'b0, 5'd0, 5'd4, 5'd4, "byp_last");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) RST_N = 1'b0;
            else RST_N = 1'b1;
            step(($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), "rand");
        end
        RST_N = 1'b1;

        drain = 0;
        while (sbq.size() > 0 && drain < 10) begin
            @(posedge CLK);
            drain++;
        end
        if (sbq.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
